// File: rtl/mips_trace_pkg.sv
// mips_trace_pkg: shared types for the MIPS trace buffer.
// Build option: define TRACE_TIMESTAMP_EN to add a 32-bit cycle timestamp
// to each record (4 stream words per record instead of 3).
package mips_trace_pkg;

    typedef enum logic [2:0] {
        IDLE,
        W_PC,
        W_ULA,
        W_MEM,
        W_TS
    } trace_state_t;

`ifdef TRACE_TIMESTAMP_EN
    localparam int RECORD_WORDS = 4;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] ula;
        logic [31:0] dmem;
        logic [31:0] ts;
    } trace_rec_t;
`else
    localparam int RECORD_WORDS = 3;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] ula;
        logic [31:0] dmem;
    } trace_rec_t;
`endif

    localparam int RECORD_W = $bits(trace_rec_t);

endpackage

// File: rtl/trace_fifo.sv
// trace_fifo: generic synchronous FIFO. A push into a full FIFO is accepted
// when a pop completes in the same cycle; pops of an empty FIFO are ignored.
module trace_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 96,
    localparam int AW = $clog2(DEPTH),
    localparam int LW = AW + 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [LW-1:0]    level
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (level == LW'(DEPTH));
    assign empty   = (level == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    // Storage array; contents need no reset since level gates every read.
    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/mips_trace_buffer.sv
// mips_trace_buffer: passive trace observer for mips_top. Captures
// {PC, ULA, MEM} records into a FIFO and streams them out as 32-bit words.
// Records arriving with no room are dropped and counted.
// Build option: TRACE_TIMESTAMP_EN appends a cycle timestamp word per record.
//
// state | meaning
// IDLE  | no record being streamed
// W_PC  | presenting head record PC word
// W_ULA | presenting head record ULA word
// W_MEM | presenting head record data-memory word
// W_TS  | presenting head record timestamp word (timestamp build only)
module mips_trace_buffer
    import mips_trace_pkg::*;
#(
    parameter int DEPTH  = 8,
    parameter int DROP_W = 16
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     cap_en,
    input  logic [31:0]              pc_in,
    input  logic [31:0]              ula_in,
    input  logic [31:0]              dmem_in,
    output logic [31:0]              out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     out_last,
    output logic                     overflow,
    output logic [DROP_W-1:0]        drop_cnt,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int LW = $clog2(DEPTH) + 1;

    trace_state_t state;
    trace_state_t state_next;
    trace_rec_t   wr_rec;
    trace_rec_t   head;
    logic         full;
    logic         empty;
    logic         pop;
    logic         push_acc;
    logic         more;

`ifdef TRACE_TIMESTAMP_EN
    logic [31:0] ts;

    // Free-running cycle counter, wraps at 2^32.
    always_ff @(posedge clock) begin
        if (reset) begin
            ts <= '0;
        end else begin
            ts <= ts + 32'd1;
        end
    end

    assign wr_rec = '{pc: pc_in, ula: ula_in, dmem: dmem_in, ts: ts};
`else
    assign wr_rec = '{pc: pc_in, ula: ula_in, dmem: dmem_in};
`endif

    assign push_acc = cap_en && (!full || pop);
    // Another record will be at the head after this pop: one already queued
    // behind it, or one being captured right now (always fits when popping).
    assign more     = (level > LW'(1)) || cap_en;

    trace_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (RECORD_W)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (cap_en),
        .pop   (pop),
        .din   (wr_rec),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .level (level)
    );

    // Stream FSM state register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state, word mux and pop. IDLE also leaves on a capture into an
    // empty FIFO so the first word is valid the cycle after capture.
    always_comb begin
        state_next = state;
        out_valid  = 1'b0;
        out_last   = 1'b0;
        out_data   = '0;
        pop        = 1'b0;
        case (state)
            IDLE: begin
                if (!empty || cap_en) begin
                    state_next = W_PC;
                end
            end
            W_PC: begin
                out_valid = 1'b1;
                out_data  = head.pc;
                if (out_ready) begin
                    state_next = W_ULA;
                end
            end
            W_ULA: begin
                out_valid = 1'b1;
                out_data  = head.ula;
                if (out_ready) begin
                    state_next = W_MEM;
                end
            end
            W_MEM: begin
                out_valid = 1'b1;
                out_data  = head.dmem;
`ifdef TRACE_TIMESTAMP_EN
                if (out_ready) begin
                    state_next = W_TS;
                end
`else
                out_last = 1'b1;
                if (out_ready) begin
                    pop        = 1'b1;
                    state_next = more ? W_PC : IDLE;
                end
`endif
            end
            W_TS: begin
`ifdef TRACE_TIMESTAMP_EN
                out_valid = 1'b1;
                out_data  = head.ts;
                out_last  = 1'b1;
                if (out_ready) begin
                    pop        = 1'b1;
                    state_next = more ? W_PC : IDLE;
                end
`else
                state_next = IDLE;
`endif
            end
            default: state_next = IDLE;
        endcase
    end

    // Sticky overflow flag and saturating drop counter.
    always_ff @(posedge clock) begin
        if (reset) begin
            overflow <= 1'b0;
            drop_cnt <= '0;
        end else if (cap_en && !push_acc) begin
            overflow <= 1'b1;
            if (drop_cnt != '1) begin
                drop_cnt <= drop_cnt + DROP_W'(1);
            end
        end
    end

endmodule
